// File: rtl/ttrpg_i2c_target.sv
// I2C target: sync+glitch filter, START/STOP decode, 1-clk reg write strobe ~FILTER_LEN+3 clk after SCL edge.
// No backpressure: SCL is never stretched; `define I2C_READ_EN adds register reads (RDATA/ACK_H).
module ttrpg_i2c_target #(
    parameter logic [6:0] I2C_ADDR   = 7'h70,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] ADDR   = 4'd1;
    localparam logic [3:0] ACK_A  = 4'd2;
    localparam logic [3:0] SUB    = 4'd3;
    localparam logic [3:0] ACK_S  = 4'd4;
    localparam logic [3:0] WDATA  = 4'd5;
    localparam logic [3:0] ACK_W  = 4'd6;
    localparam logic [3:0] RDATA  = 4'd7;
    localparam logic [3:0] ACK_H  = 4'd8;
    localparam logic [3:0] IGNORE = 4'd9;

    localparam int CW = $clog2(FILTER_LEN + 1);

    // Index 0 = SCL, index 1 = SDA. Idle bus level is high, so reset to 1 to avoid false edges.
    logic [1:0]    meta;
    logic [1:0]    sync;
    logic [1:0]    filt;
    logic [1:0]    filt_q;
    logic [CW-1:0] fcnt [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta    <= 2'b11;
            sync    <= 2'b11;
            filt    <= 2'b11;
            filt_q  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            meta   <= {sda_in, scl_in};
            sync   <= meta;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_f;

    assign sda_f     = filt[1];
    assign scl_rise  = filt[0] & ~filt_q[0];
    assign scl_fall  = ~filt[0] & filt_q[0];
    assign start_det = filt_q[1] & ~filt[1] & filt[0] & filt_q[0];
    assign stop_det  = ~filt_q[1] & filt[1] & filt[0] & filt_q[0];

    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [6:0] shift;
    logic [7:0] rx_byte;
    logic       byte_full;

    assign rx_byte   = {shift, sda_f};
    assign byte_full = (bit_cnt == 4'd8);
    assign busy      = (state != IDLE) && (state != IGNORE);

`ifdef I2C_READ_EN
    logic rw_bit;
`else
    logic unused_rd;
    assign unused_rd = ^reg_rd_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            sda_oe      <= 1'b0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
`ifdef I2C_READ_EN
            rw_bit      <= 1'b0;
`endif
        end else begin
            reg_wr_en <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    ADDR, SUB, WDATA: begin
                        // Bits shift in on SCL rise; the fall after the 8th bit opens the ACK slot.
                        if (scl_rise && !byte_full) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (state == ADDR) begin
`ifdef I2C_READ_EN
                                    if (rx_byte[7:1] != I2C_ADDR) state <= IGNORE;
                                    rw_bit <= rx_byte[0];
`else
                                    if (rx_byte[7:1] != I2C_ADDR) state <= IGNORE;
                                    else if (rx_byte[0]) state <= IGNORE;
`endif
                                end else if (state == SUB) begin
                                    reg_addr <= rx_byte;
                                end else begin
                                    reg_wr_en   <= 1'b1;
                                    reg_wr_data <= rx_byte;
                                end
                            end
                        end else if (scl_fall && byte_full) begin
                            sda_oe  <= 1'b1;
                            bit_cnt <= '0;
                            state   <= (state == ADDR) ? ACK_A : (state == SUB) ? ACK_S : ACK_W;
                        end
                    end
                    ACK_A: begin
                        if (scl_fall) begin
`ifdef I2C_READ_EN
                            if (rw_bit) begin
                                state   <= RDATA;
                                shift   <= reg_rd_data[6:0];
                                sda_oe  <= ~reg_rd_data[7];
                                bit_cnt <= '0;
                            end else begin
                                state  <= SUB;
                                sda_oe <= 1'b0;
                            end
`else
                            state  <= SUB;
                            sda_oe <= 1'b0;
`endif
                        end
                    end
                    ACK_S: begin
                        if (scl_fall) begin
                            state  <= WDATA;
                            sda_oe <= 1'b0;
                        end
                    end
                    ACK_W: begin
                        if (scl_fall) begin
                            state    <= WDATA;
                            sda_oe   <= 1'b0;
                            reg_addr <= reg_addr + 8'd1;
                        end
                    end
`ifdef I2C_READ_EN
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ACK_H;
                            end else begin
                                sda_oe  <= ~shift[6];
                                shift   <= {shift[5:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ACK_H: begin
                        // Advance the pointer on the host ACK so the next fall latches the new address.
                        if (scl_rise) begin
                            if (sda_f) begin
                                state <= IGNORE;
                            end else begin
                                reg_addr <= reg_addr + 8'd1;
                                bit_cnt  <= 4'd1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            state   <= RDATA;
                            shift   <= reg_rd_data[6:0];
                            sda_oe  <= ~reg_rd_data[7];
                            bit_cnt <= '0;
                        end
                    end
`endif
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ttrpg_i2c_target.sv
// Directed bench for ttrpg_i2c_target: bus-level host tasks, write scoreboard queue, immediate-assert checks.
module tb_ttrpg_i2c_target;
    localparam int Q = 100;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       scl_h = 1'b1;
    logic       sda_h = 1'b1;
    logic       sda_oe;
    logic       reg_wr_en;
    logic       busy;
    logic [7:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic [7:0] reg_rd_data;
    logic       sda_bus;

    assign sda_bus     = sda_h & ~sda_oe;
    assign reg_rd_data = reg_addr + 8'h80;

    always #5 clk = ~clk;

    ttrpg_i2c_target #(.I2C_ADDR(7'h70), .FILTER_LEN(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .scl_in      (scl_h),
        .sda_in      (sda_bus),
        .sda_oe      (sda_oe),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data),
        .busy        (busy)
    );

    int          checks   = 0;
    int          failures = 0;
    int          wr_count = 0;
    logic        oe_seen  = 1'b0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (reg_wr_en) begin
            wr_count++;
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("wr_addr_data", {16'h0, reg_addr, reg_wr_data}, {16'h0, exp_q.pop_front()});
        end
    end

    task automatic i2c_start();
        sda_h = 1'b1; #Q;
        scl_h = 1'b1; #Q;
        sda_h = 1'b0; #Q;
        scl_h = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_h = 1'b0; #Q;
        scl_h = 1'b1; #Q;
        sda_h = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        sda_h = b; #Q;
        scl_h = 1'b1; #Q;
        if (glitch) begin
            sda_h = ~b; #10;
            sda_h = b;  #(Q - 10);
        end else begin
            #Q;
        end
        scl_h = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_h = 1'b1; #Q;
        scl_h = 1'b1; #Q;
        b = sda_bus;  #Q;
        scl_h = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i], gmask[i]);
        read_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(input logic nak, output logic [7:0] b);
        logic v;
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            b[i] = v;
        end
        write_bit(nak, 1'b0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         wr_base;

        #20;
        check("rst_ctrl", {29'h0, sda_oe, reg_wr_en, busy}, 32'h0);
        check("rst_addr", {24'h0, reg_addr}, 32'h0);
        check("rst_wdata", {24'h0, reg_wr_data}, 32'h0);
        #80 rst = 1'b0;
        #200;

        // Two-byte write with pointer auto-increment.
        i2c_start();
        write_byte(8'hE0, 8'h00, ack); check("t1_ack_addr", 32'(ack), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        write_byte(8'h0A, 8'h00, ack); check("t1_ack_sub", 32'(ack), 32'd1);
        exp_q.push_back({8'h0A, 8'h55});
        write_byte(8'h55, 8'h00, ack); check("t1_ack_d0", 32'(ack), 32'd1);
        exp_q.push_back({8'h0B, 8'h1F});
        write_byte(8'h1F, 8'h00, ack); check("t1_ack_d1", 32'(ack), 32'd1);
        i2c_stop(); #Q;
        check("t1_wr_count", 32'(wr_count), 32'd2);
        check("t1_addr_after", {24'h0, reg_addr}, 32'h0C);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Foreign address: no ACK, no writes, busy drops after the address byte.
        oe_seen = 1'b0;
        wr_base = wr_count;
        i2c_start();
        write_byte(8'hE2, 8'h00, ack); check("t2_nak_addr", 32'(ack), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            write_byte(8'h3C + 8'(i), 8'h00, ack);
            check("t2_nak_data", 32'(ack), 32'd0);
        end
        i2c_stop(); #Q;
        check("t2_oe_seen", 32'(oe_seen), 32'd0);
        check("t2_wr_count", 32'(wr_count - wr_base), 32'd0);

        // Pointer wrap 0xFF -> 0x00.
        i2c_start();
        write_byte(8'hE0, 8'h00, ack); check("t3_ack_addr", 32'(ack), 32'd1);
        write_byte(8'hFF, 8'h00, ack); check("t3_ack_sub", 32'(ack), 32'd1);
        exp_q.push_back({8'hFF, 8'h11});
        write_byte(8'h11, 8'h00, ack); check("t3_ack_d0", 32'(ack), 32'd1);
        exp_q.push_back({8'h00, 8'h22});
        write_byte(8'h22, 8'h00, ack); check("t3_ack_d1", 32'(ack), 32'd1);
        i2c_stop(); #Q;
        check("t3_addr_after", {24'h0, reg_addr}, 32'h01);

        // Set pointer, repeated START, read address.
        i2c_start();
        write_byte(8'hE0, 8'h00, ack); check("t4_ack_addr", 32'(ack), 32'd1);
        write_byte(8'h05, 8'h00, ack); check("t4_ack_sub", 32'(ack), 32'd1);
        i2c_start();
        write_byte(8'hE1, 8'h00, ack);
`ifdef I2C_READ_EN
        check("t4_ack_raddr", 32'(ack), 32'd1);
        read_byte(1'b0, rb); check("t4_rd0", {24'h0, rb}, 32'h85);
        read_byte(1'b1, rb); check("t4_rd1", {24'h0, rb}, 32'h86);
        check("t4_oe_released", 32'(sda_oe), 32'd0);
        check("t4_busy_ignore", 32'(busy), 32'd0);
        i2c_stop(); #Q;
        check("t4_addr_after", {24'h0, reg_addr}, 32'h06);
`else
        rb = 8'h00;
        check("t4_nak_raddr", 32'(ack), 32'd0);
        check("t4_busy_ignore", {24'h0, rb} | 32'(busy), 32'd0);
        i2c_stop(); #Q;
        check("t4_addr_after", {24'h0, reg_addr}, 32'h05);
`endif

        // Reset during the 5th bit of a data byte.
        wr_base = wr_count;
        i2c_start();
        write_byte(8'hE0, 8'h00, ack); check("t5_ack_addr", 32'(ack), 32'd1);
        write_byte(8'h30, 8'h00, ack); check("t5_ack_sub", 32'(ack), 32'd1);
        for (int i = 7; i >= 4; i--) write_bit(1'(8'hAA >> i), 1'b0);
        sda_h = 1'b1; #Q;
        scl_h = 1'b1; #Q;
        rst = 1'b1; #1;
        check("t5_rst_ctrl", {29'h0, sda_oe, reg_wr_en, busy}, 32'h0);
        check("t5_rst_addr", {24'h0, reg_addr}, 32'h0);
        check("t5_rst_wdata", {24'h0, reg_wr_data}, 32'h0);
        #9;
        scl_h = 1'b0; #Q;
        i2c_stop(); #Q;
        rst = 1'b0; #(2 * Q);
        check("t5_no_write", 32'(wr_count - wr_base), 32'd0);
        i2c_start();
        write_byte(8'hE0, 8'h00, ack); check("t5_ack_addr2", 32'(ack), 32'd1);
        write_byte(8'h40, 8'h00, ack); check("t5_ack_sub2", 32'(ack), 32'd1);
        exp_q.push_back({8'h40, 8'h99});
        write_byte(8'h99, 8'h00, ack); check("t5_ack_d0", 32'(ack), 32'd1);
        i2c_stop(); #Q;
        check("t5_addr_after", {24'h0, reg_addr}, 32'h41);

        // One-clk SDA glitches while SCL high: fake START on bit 7, fake STOP on bit 5.
        i2c_start();
        write_byte(8'hE0, 8'h00, ack); check("t6_ack_addr", 32'(ack), 32'd1);
        write_byte(8'h50, 8'h00, ack); check("t6_ack_sub", 32'(ack), 32'd1);
        exp_q.push_back({8'h50, 8'hC3});
        write_byte(8'hC3, 8'hA0, ack); check("t6_ack_data", 32'(ack), 32'd1);
        check("t6_busy", 32'(busy), 32'd1);
        i2c_stop(); #Q;
        check("t6_addr_after", {24'h0, reg_addr}, 32'h51);

        #(4 * Q);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
